hough_pt_reader: RTL and testbench

- Multi-channel read-address generator for the feature-point RAMs that feed the rho calculation stage.
- Each channel is one region of interest: left lane, right lane, and so on.
- On every frame after the first, each channel reads back exactly the number of points stored in the previous frame, paced by axis_de and a downstream hold.
- Emits RAM read enables and addresses, a data-valid strobe aligned to the RAM read latency, per-channel last markers and a frame-done pulse.

---
 rtl/hough_rd_pkg.sv | 16 +
 rtl/hough_rd_chan.sv | 105 ++++++++++
 rtl/hough_pt_reader.sv | 90 +++++++++
 tb/tb_hough_pt_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_rd_pkg.sv
// rtl/hough_rd_pkg.sv - shared state encoding and count clamp for the point reader
package hough_rd_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // A RAM of 2**addr_w entries can never hold more points than its depth,
   // so larger stored counts are limited to the full depth.
   function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned addr_w);
      int unsigned lim;
      lim = 32'd1 << addr_w;
      return (cnt > lim) ? lim : cnt;
   endfunction

endpackage

// File: rtl/hough_rd_chan.sv
// rtl/hough_rd_chan.sv - one ROI channel: read FSM, address counter, count latch, latency pipe
module hough_rd_chan
   import hough_rd_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              slot,
   input  logic [ADDR_W:0]   cnt_in,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_last,
   output logic              data_vld,
   output logic              data_last,
   output logic              running,
   output logic              done_nxt
);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [ADDR_W:0]    cnt_q;
   logic [ADDR_W:0]    cnt_clamp;
   logic [ADDR_W-1:0]  ctr_q;
   logic               is_last;
   logic               issue;
   logic [RAM_LAT-1:0] vld_sr;
   logic [RAM_LAT-1:0] last_sr;

   assign cnt_clamp = (ADDR_W+1)'(clamp_cnt(32'(cnt_in), ADDR_W));

   // The counter never passes cnt_q-1, so a full-depth count reads every address once without wrapping.
   assign is_last = ({1'b0, ctr_q} == (cnt_q - (ADDR_W+1)'(1)));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: a frame start always restarts the channel, even mid-run (abort)
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = (cnt_clamp == '0) ? DONE : RUN;
         end
         RUN: begin
            if (start)                state_nxt = (cnt_clamp == '0) ? DONE : RUN;
            else if (slot && is_last) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: a read is issued for every granted slot while running
   always_comb begin
      issue    = (state == RUN) && slot && !start;
      running  = (state == RUN);
      done_nxt = (state_nxt == DONE);
   end

   // Count latch and address counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ctr_q <= '0;
      end else if (start) begin
         cnt_q <= cnt_clamp;
         ctr_q <= '0;
      end else if (issue) begin
         ctr_q <= ctr_q + ADDR_W'(1);
      end
   end

   // Registered read strobes; the address holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en   <= 1'b0;
         rd_last <= 1'b0;
         rd_addr <= '0;
      end else begin
         rd_en   <= issue;
         rd_last <= issue && is_last;
         if (issue) rd_addr <= ctr_q;
      end
   end

   // Latency pipe aligning the valid/last strobes with RAM output data; keeps shifting through aborts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr  <= '0;
         last_sr <= '0;
      end else begin
         vld_sr  <= RAM_LAT'({vld_sr, rd_en});
         last_sr <= RAM_LAT'({last_sr, rd_last});
      end
   end

   assign data_vld  = vld_sr[RAM_LAT-1];
   assign data_last = last_sr[RAM_LAT-1];

endmodule

// File: rtl/hough_pt_reader.sv
// rtl/hough_pt_reader.sv - multi-channel feature-point RAM read-address generator
module hough_pt_reader
   import hough_rd_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 8,
   parameter int RAM_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       axis_vsync,
   input  logic                       axis_de,
   input  logic                       rd_hold,
   input  logic [NUM_CH*(ADDR_W+1)-1:0] pt_cnt,
   output logic [NUM_CH-1:0]          rd_en,
   output logic [NUM_CH*ADDR_W-1:0]   rd_addr,
   output logic [NUM_CH-1:0]          rd_last,
   output logic [NUM_CH-1:0]          data_vld,
   output logic [NUM_CH-1:0]          data_last,
   output logic                       frame_done,
   output logic                       abort
);

   localparam int CW = ADDR_W + 1;

   logic              vs_d;
   logic              vs_neg;
   logic              armed;
   logic              start;
   logic              slot;
   logic              pend;
   logic              any_run;
   logic              all_done;
   logic [NUM_CH-1:0] running;
   logic [NUM_CH-1:0] done_nxt;

   // Frame 0 RAM content is garbage, so the first falling vsync only arms the reader.
   assign vs_neg   = ~axis_vsync & vs_d;
   assign start    = vs_neg & armed;
   assign slot     = axis_de & ~rd_hold & ~vs_neg;
   assign any_run  = |running;
   assign all_done = &done_nxt;

   // Vsync edge detection and arming
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d  <= 1'b0;
         armed <= 1'b0;
      end else begin
         vs_d <= axis_vsync;
         if (vs_neg) armed <= 1'b1;
      end
   end

   // Frame status: one done pulse per started frame, abort when a restart cuts a frame short
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         abort      <= 1'b0;
         frame_done <= 1'b0;
         pend       <= 1'b0;
      end else begin
         abort      <= start & any_run;
         frame_done <= (start | pend) & all_done;
         if (start)         pend <= ~all_done;
         else if (all_done) pend <= 1'b0;
      end
   end

   // One reader per ROI channel, all sharing the same read slots
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      hough_rd_chan #(
         .ADDR_W  (ADDR_W),
         .RAM_LAT (RAM_LAT)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start),
         .slot      (slot),
         .cnt_in    (pt_cnt[c*CW +: CW]),
         .rd_en     (rd_en[c]),
         .rd_addr   (rd_addr[c*ADDR_W +: ADDR_W]),
         .rd_last   (rd_last[c]),
         .data_vld  (data_vld[c]),
         .data_last (data_last[c]),
         .running   (running[c]),
         .done_nxt  (done_nxt[c])
      );
   end

endmodule

// File: tb/tb_hough_pt_reader.sv
// tb/tb_hough_pt_reader.sv - scoreboard bench for hough_pt_reader
module tb_hough_pt_reader;

   localparam int NUM_CH  = 2;
   localparam int ADDR_W  = 8;
   localparam int RAM_LAT = 1;
   localparam int CW      = ADDR_W + 1;

   logic                     clk;
   logic                     rst_n;
   logic                     axis_vsync;
   logic                     axis_de;
   logic                     rd_hold;
   logic [NUM_CH*CW-1:0]     pt_cnt;
   logic [NUM_CH-1:0]        rd_en;
   logic [NUM_CH*ADDR_W-1:0] rd_addr;
   logic [NUM_CH-1:0]        rd_last;
   logic [NUM_CH-1:0]        data_vld;
   logic [NUM_CH-1:0]        data_last;
   logic                     frame_done;
   logic                     abort;

   hough_pt_reader #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .axis_vsync (axis_vsync),
      .axis_de    (axis_de),
      .rd_hold    (rd_hold),
      .pt_cnt     (pt_cnt),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_last    (rd_last),
      .data_vld   (data_vld),
      .data_last  (data_last),
      .frame_done (frame_done),
      .abort      (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_CH-1:0]        en;
      logic [NUM_CH-1:0]        last;
      logic [NUM_CH*ADDR_W-1:0] addr;
      logic                     fd;
      logic                     ab;
   } exp_t;

   exp_t expq[$];

   int checks = 0;
   int failures = 0;

   // reference model state
   bit                m_armed, m_vs_d, m_pend;
   bit                m_run  [NUM_CH];
   int                m_cnt  [NUM_CH];
   int                m_ctr  [NUM_CH];
   logic [ADDR_W-1:0] m_addr [NUM_CH];

   // monitor statistics
   int n_rd [NUM_CH];
   int n_fd, n_ab, n_last1, fd_cyc, last1_cyc, cyc;
   logic [NUM_CH-1:0] vpipe [RAM_LAT];
   logic [NUM_CH-1:0] lpipe [RAM_LAT];
   exp_t me;

   task automatic model_reset();
      m_armed = 0; m_vs_d = 0; m_pend = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_run[c] = 0; m_cnt[c] = 0; m_ctr[c] = 0; m_addr[c] = '0;
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < NUM_CH; c++) n_rd[c] = 0;
      n_fd = 0; n_ab = 0; n_last1 = 0; fd_cyc = -1; last1_cyc = -2;
   endtask

   // Drive one clock cycle of input and push the model's expectation for the resulting edge.
   task automatic cycle(input logic vs, input logic de, input logic hold);
      exp_t e;
      bit   vneg, anyrun, allz;
      int   cnt;
      axis_vsync = vs; axis_de = de; rd_hold = hold;
      e = '0;
      vneg = !vs && m_vs_d;
      if (vneg) begin
         if (m_armed) begin
            anyrun = 0;
            for (int c = 0; c < NUM_CH; c++) anyrun |= m_run[c];
            e.ab = anyrun;
            allz = 1;
            for (int c = 0; c < NUM_CH; c++) begin
               cnt = int'(pt_cnt[c*CW +: CW]);
               if (cnt > (1 << ADDR_W)) cnt = 1 << ADDR_W;
               m_cnt[c] = cnt; m_ctr[c] = 0; m_run[c] = (cnt != 0);
               if (cnt != 0) allz = 0;
            end
            if (allz) begin e.fd = 1; m_pend = 0; end
            else m_pend = 1;
         end else begin
            m_armed = 1;
         end
      end else if (de && !hold) begin
         anyrun = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (m_run[c]) begin
               e.en[c] = 1;
               m_addr[c] = m_ctr[c][ADDR_W-1:0];
               if (m_ctr[c] == m_cnt[c] - 1) begin
                  e.last[c] = 1; m_run[c] = 0;
               end
               m_ctr[c]++;
            end
            anyrun |= m_run[c];
         end
         if (m_pend && !anyrun) begin e.fd = 1; m_pend = 0; end
      end
      for (int c = 0; c < NUM_CH; c++) e.addr[c*ADDR_W +: ADDR_W] = m_addr[c];
      m_vs_d = vs;
      expq.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic vs_fall();
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
   endtask

   task automatic drain();
      @(negedge clk); #1;
   endtask

   // Scoreboard: pop one expectation per driven cycle and compare every output
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         for (int i = 0; i < RAM_LAT; i++) begin vpipe[i] = '0; lpipe[i] = '0; end
      end else if (expq.size() > 0) begin
         me = expq.pop_front();
         checks++;
         if (rd_en !== me.en) begin
            failures++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, me.en);
         end
         checks++;
         if (rd_last !== me.last) begin
            failures++; $display("FAIL rd_last cyc=%0d got=%b exp=%b", cyc, rd_last, me.last);
         end
         checks++;
         if (rd_addr !== me.addr) begin
            failures++; $display("FAIL rd_addr cyc=%0d got=%h exp=%h", cyc, rd_addr, me.addr);
         end
         checks++;
         if (frame_done !== me.fd) begin
            failures++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, me.fd);
         end
         checks++;
         if (abort !== me.ab) begin
            failures++; $display("FAIL abort cyc=%0d got=%b exp=%b", cyc, abort, me.ab);
         end
         checks++;
         if (data_vld !== vpipe[RAM_LAT-1]) begin
            failures++; $display("FAIL data_vld cyc=%0d got=%b exp=%b", cyc, data_vld, vpipe[RAM_LAT-1]);
         end
         checks++;
         if (data_last !== lpipe[RAM_LAT-1]) begin
            failures++; $display("FAIL data_last cyc=%0d got=%b exp=%b", cyc, data_last, lpipe[RAM_LAT-1]);
         end
         for (int i = RAM_LAT - 1; i > 0; i--) begin vpipe[i] = vpipe[i-1]; lpipe[i] = lpipe[i-1]; end
         vpipe[0] = me.en;
         lpipe[0] = me.last;
         for (int c = 0; c < NUM_CH; c++) if (rd_en[c]) n_rd[c]++;
         if (rd_last[1]) begin n_last1++; last1_cyc = cyc; end
         if (frame_done) begin n_fd++; fd_cyc = cyc; end
         if (abort) n_ab++;
      end
   end

   task automatic test_reset();
      rst_n = 0; axis_vsync = 0; axis_de = 0; rd_hold = 0;
      pt_cnt = {9'd5, 9'd3};
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rd_en, rd_addr, rd_last, data_vld, data_last, frame_done, abort} !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", {rd_en, rd_addr, rd_last, data_vld, data_last, frame_done, abort});
      end
      rst_n = 1;
   endtask

   task automatic test_first_frame();
      clear_stats();
      vs_fall();
      repeat (20) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_rd[0] + n_rd[1] != 0) begin
         failures++; $display("FAIL first_frame_reads got=%0d exp=0", n_rd[0] + n_rd[1]);
      end
      checks++;
      if (n_fd != 0) begin failures++; $display("FAIL first_frame_done got=%0d exp=0", n_fd); end
   endtask

   task automatic test_second_frame();
      clear_stats();
      vs_fall();
      repeat (20) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_rd[0] != 3) begin failures++; $display("FAIL frame2_ch0_reads got=%0d exp=3", n_rd[0]); end
      checks++;
      if (n_rd[1] != 5) begin failures++; $display("FAIL frame2_ch1_reads got=%0d exp=5", n_rd[1]); end
      checks++;
      if (n_fd != 1) begin failures++; $display("FAIL frame2_done_count got=%0d exp=1", n_fd); end
      checks++;
      if (fd_cyc != last1_cyc) begin
         failures++; $display("FAIL frame2_done_align got=%0d exp=%0d", fd_cyc, last1_cyc);
      end
   endtask

   task automatic test_hold();
      clear_stats();
      vs_fall();
      for (int i = 0; i < 20; i++) cycle(0, 1, logic'(i % 2));
      drain();
      checks++;
      if (n_rd[0] != 3 || n_rd[1] != 5) begin
         failures++; $display("FAIL hold_reads got=%0d/%0d exp=3/5", n_rd[0], n_rd[1]);
      end
      checks++;
      if (n_fd != 1) begin failures++; $display("FAIL hold_done_count got=%0d exp=1", n_fd); end
   endtask

   task automatic test_boundary();
      pt_cnt = {9'd256, 9'd0};
      clear_stats();
      vs_fall();
      repeat (260) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_rd[0] != 0 || n_rd[1] != 256) begin
         failures++; $display("FAIL full_depth_reads got=%0d/%0d exp=0/256", n_rd[0], n_rd[1]);
      end
      checks++;
      if (n_fd != 1 || n_last1 != 1) begin
         failures++; $display("FAIL full_depth_done got=%0d/%0d exp=1/1", n_fd, n_last1);
      end
      pt_cnt = {9'd300, 9'd1};
      clear_stats();
      vs_fall();
      repeat (260) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_rd[0] != 1 || n_rd[1] != 256) begin
         failures++; $display("FAIL clamp_reads got=%0d/%0d exp=1/256", n_rd[0], n_rd[1]);
      end
   endtask

   task automatic test_all_zero();
      pt_cnt = '0;
      clear_stats();
      vs_fall();
      repeat (5) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_fd != 1 || n_rd[0] + n_rd[1] != 0) begin
         failures++; $display("FAIL all_zero got fd=%0d rd=%0d exp fd=1 rd=0", n_fd, n_rd[0] + n_rd[1]);
      end
   endtask

   task automatic test_abort();
      pt_cnt = {9'd100, 9'd100};
      clear_stats();
      vs_fall();
      repeat (40) cycle(0, 1, 0);
      vs_fall();
      repeat (110) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_ab != 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", n_ab); end
      checks++;
      if (n_rd[1] != 140) begin failures++; $display("FAIL abort_reads got=%0d exp=140", n_rd[1]); end
      checks++;
      if (n_fd != 1) begin failures++; $display("FAIL abort_done_count got=%0d exp=1", n_fd); end
   endtask

   task automatic test_reset_mid();
      pt_cnt = {9'd100, 9'd100};
      vs_fall();
      repeat (10) cycle(0, 1, 0);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if ({rd_en, rd_addr, rd_last, data_vld, data_last, frame_done, abort} !== '0) begin
         failures++; $display("FAIL mid_reset_outputs got=%h exp=0", {rd_en, rd_addr, rd_last, data_vld, data_last, frame_done, abort});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      clear_stats();
      vs_fall();
      repeat (20) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_rd[0] + n_rd[1] != 0) begin
         failures++; $display("FAIL post_reset_skip got=%0d exp=0", n_rd[0] + n_rd[1]);
      end
      clear_stats();
      vs_fall();
      repeat (20) cycle(0, 1, 0);
      drain();
      checks++;
      if (n_rd[0] != 20 || n_rd[1] != 20) begin
         failures++; $display("FAIL post_reset_resume got=%0d/%0d exp=20/20", n_rd[0], n_rd[1]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      cyc = 0;
      clear_stats();
      test_reset();
      test_first_frame();
      test_second_frame();
      test_hold();
      test_boundary();
      test_all_zero();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
